// File: rtl/neuron_result_collector.sv
// Picks one of the neuron's three activation results per sample, canonicalises it
// and queues it in a small FIFO that feeds the next layer over valid/ready.
module neuron_result_collector #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     InValid,
    input  logic [1:0]               Select,
    input  logic                     SignT,
    input  logic [4:0]               ExponentT,
    input  logic [5:0]               MantissaT,
    input  logic                     SignS,
    input  logic [4:0]               ExponentS,
    input  logic [5:0]               MantissaS,
    input  logic                     SignR,
    input  logic [4:0]               ExponentR,
    input  logic [5:0]               MantissaR,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic                     SignOut,
    output logic [4:0]               ExponentOut,
    output logic [5:0]               MantissaOut,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Overflow,
    input  logic                     ClearOvf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [LW-1:0] LVL_ONE = 1;

    logic       tapValid;
    logic [1:0] tapSel;

    // The delay line aligns each sample's select code with the cycle its results appear.
    generate
        if (LATENCY == 0) begin : gNoDelay
            assign tapValid = InValid;
            assign tapSel   = Select;
        end else begin : gDelay
            logic [LATENCY-1:0] validPipe;
            logic [1:0]         selPipe [LATENCY];

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    validPipe <= '0;
                    for (int i = 0; i < LATENCY; i++) selPipe[i] <= '0;
                end else begin
                    validPipe[0] <= InValid;
                    selPipe[0]   <= Select;
                    for (int i = 1; i < LATENCY; i++) begin
                        validPipe[i] <= validPipe[i-1];
                        selPipe[i]   <= selPipe[i-1];
                    end
                end
            end

            assign tapValid = validPipe[LATENCY-1];
            assign tapSel   = selPipe[LATENCY-1];
        end
    endgenerate

    logic [11:0] rawWord;
    logic [11:0] canonWord;

    always_comb begin
        rawWord = '0;
        case (tapSel)
            2'b00:   rawWord = {SignT, ExponentT, MantissaT};
            2'b01:   rawWord = {SignS, ExponentS, MantissaS};
            default: rawWord = {SignR, ExponentR, MantissaR};
        endcase
        // A zero exponent is flushed to a clean +0 regardless of sign or mantissa.
        canonWord = (rawWord[10:6] == 5'd0) ? 12'd0 : rawWord;
    end

    // Handshake: the head transfers on a rising edge where OutValid && OutReady;
    // while OutValid=1 and OutReady=0 the head and OutValid hold steady.
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          full;
    logic          pop;
    logic          wrEn;

    assign full     = (Level == LW'(DEPTH));
    assign OutValid = (Level != '0);
    assign pop      = OutValid & OutReady;
    assign wrEn     = tapValid & (~full | pop);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            Level    <= '0;
            Overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wrEn) begin
                mem[wrPtr] <= canonWord;
                wrPtr      <= wrPtr + PTR_ONE;
            end
            if (pop) rdPtr <= rdPtr + PTR_ONE;
            if (wrEn && !pop) Level <= Level + LVL_ONE;
            else if (pop && !wrEn) Level <= Level - LVL_ONE;
            // A fresh drop wins over a simultaneous clear.
            if (tapValid && full && !pop) Overflow <= 1'b1;
            else if (ClearOvf) Overflow <= 1'b0;
        end
    end

    assign {SignOut, ExponentOut, MantissaOut} = mem[rdPtr];

endmodule

// File: doc/neuron_result_collector.md
# neuron_result_collector

Output stage placed directly downstream of the neuron datapath. It takes the three activation results (tanh, sigmoid, ReLU) the neuron produces from one shared sum, and keeps the one chosen by a per-sample select code. The selected 12-bit float (1 sign, 5 exponent, 6 mantissa) is canonicalised and buffered in a small FIFO. The FIFO presents results to the next layer over a valid/ready handshake.

## Interface
- LATENCY, 2: cycles from InValid to the cycle the activation outputs hold that sample's result; legal 0..7
- DEPTH, 4: FIFO entries; power of two, 2..16
- Clock  input  1  rising-edge clock
- Resetn  input  1  asynchronous active-low reset
- InValid  input  1  one-cycle pulse per neuron sample launched
- Select  input  2  activation for this sample: 00 tanh, 01 sigmoid, 10 ReLU, 11 ReLU (reserved alias)
- SignT, ExponentT, MantissaT  input  1/5/6  tanh result
- SignS, ExponentS, MantissaS  input  1/5/6  sigmoid result
- SignR, ExponentR, MantissaR  input  1/5/6  ReLU result
- OutValid  output  1  FIFO head valid
- OutReady  input  1  consumer accepts head
- SignOut, ExponentOut, MantissaOut  output  1/5/6  FIFO head
- Level  output  clog2(DEPTH)+1  current FIFO occupancy
- Overflow  output  1  sticky: a result was dropped because the FIFO was full
- ClearOvf  input  1  synchronous clear of Overflow

## Operation
- Delay line:
  - LATENCY-stage shift register carries {InValid, Select}.
  - Tap = stage LATENCY. For LATENCY=0 the tap is the live inputs.
  - Back-to-back InValid every cycle must be supported; each sample keeps its own Select.
- Selection: at the cycle where the tapped valid is 1, the tapped Select picks one of the three activation input groups.
- Canonicalisation: if the selected exponent is 0, write sign=0, exponent=0, mantissa=0. Otherwise pass the value unchanged.
- FIFO write: push = tapped valid.
- FIFO read: pop = OutValid & OutReady.
- Full FIFO:
  - push without pop: result dropped, Overflow set, Level unchanged.
  - push with pop: both succeed, Level unchanged, no overflow.
- Empty FIFO: pop impossible (OutValid=0). A push into an empty FIFO is not visible as OutValid until the next cycle; there is no fall-through.
- Pointers wrap modulo DEPTH. Level = write count minus read count, range 0..DEPTH.
- Overflow stays set until ClearOvf=1 at an edge. If ClearOvf and a new overflow occur in the same cycle, Overflow remains 1.
- Outputs SignOut/ExponentOut/MantissaOut show the head entry, combinational from the FIFO storage. Their value is don't-care while OutValid=0.

## Timing
- Reset (Resetn=0, asynchronous): delay line cleared, pointers 0, Level=0, OutValid=0, Overflow=0, SignOut/ExponentOut/MantissaOut=0.
- Reset mid-operation discards all queued and in-flight samples. Release is synchronous to Clock.
- Activation inputs are sampled at the end of cycle t+LATENCY for an InValid in cycle t.
- Latency InValid→OutValid is LATENCY+1 cycles when the FIFO is empty.
- Head advances one cycle after the pop edge.
- Throughput: one result per cycle sustained when OutReady=1.
- Handshake: OutValid and the head data are stable while OutValid=1 and OutReady=0. OutReady may toggle freely.

## Test plan
- Single sample, LATENCY=2:
  - Stimulus: InValid at cycle 0 with Select=01; sigmoid inputs hold S=0,E=01111,M=100000 at cycle 2.
  - Required: OutValid=1 from cycle 3 with head 0/01111/100000; Level=1.
  - Then OutReady=1 → Level=0 and OutValid=0 the next cycle.
- Back-to-back selects:
  - Stimulus: four consecutive InValid pulses with Select=00,01,10,11; each activation group carries a distinct value.
  - Required: FIFO outputs tanh, sigmoid, ReLU, ReLU values in order.
- Zero canonicalisation:
  - Stimulus: selected value 1/00000/101010.
  - Required: stored as 0/00000/000000.
- Overflow, DEPTH=4, OutReady=0:
  - Stimulus: 5 pushes.
  - Required: Level=4, Overflow=1, and the first four values are retained in order.
  - Then ClearOvf=1 for one cycle → Overflow=0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; OutReady=1 and a push in the same cycle.
  - Required: Level stays 4, no overflow, new value lands at the tail.
- Asynchronous reset:
  - Stimulus: Resetn asserted mid-cycle with 3 entries queued and 2 samples in the delay line.
  - Required: OutValid=0 and Level=0 immediately; nothing emerges after release.
